// File: rtl/a23_cache_flush_ctrl.sv
// Cache invalidation sequencer: walks every tag line writing valid=0, and registers address cacheability.
// Optional build macro A23_FLUSH_ON_RESET_EN starts a full flush automatically on the first edge after reset.
//
// state | meaning
// IDLE  | no flush in progress
// FLUSH | writing one tag line per cycle, stalling the core
// DONE  | one-cycle completion pulse after the last line
module a23_cache_flush_ctrl #(
  parameter int CACHE_LINES = 256,
  localparam int IDX_W = $clog2(CACHE_LINES)
) (
  input  logic             i_clk,
  input  logic             i_system_rdy,
  input  logic             i_fetch_stall,
  input  logic             i_cache_enable,
  input  logic             i_cache_flush,
  input  logic [31:0]      i_cacheable_area,
  input  logic [31:0]      i_address,
  output logic             o_tag_wenable,
  output logic [IDX_W-1:0] o_tag_waddr,
  output logic             o_tag_valid,
  output logic             o_flush_busy,
  output logic             o_flush_done,
  output logic             o_cacheable
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CACHE_LINES - 1);

  logic [1:0]       state, state_next;
  logic [IDX_W-1:0] idx, idx_next, waddr_q;
  logic             cacheable_q, cacheable_d;
  logic             busy_next;
  logic             flush_req;
  logic             unused_addr_low;

  assign unused_addr_low = ^i_address[20:0];

`ifdef A23_FLUSH_ON_RESET_EN
  logic boot_q;

  always_ff @(posedge i_clk or negedge i_system_rdy) begin
    if (!i_system_rdy) boot_q <= 1'b1;
    else               boot_q <= 1'b0;
  end

  assign flush_req = i_cache_flush | boot_q;
`else
  assign flush_req = i_cache_flush;
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (flush_req) begin
          state_next = ST_FLUSH;
          idx_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // a new request restarts the walk without passing through DONE
        if (flush_req) begin
          idx_next = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
          if (idx == LAST_IDX) state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign busy_next   = (state_next == ST_FLUSH);
  assign cacheable_d = i_cache_enable & (i_address[31:26] == 6'd0) &
                       i_cacheable_area[i_address[25:21]] & ~busy_next;

  always_ff @(posedge i_clk or negedge i_system_rdy) begin
    if (!i_system_rdy) begin
      state       <= ST_IDLE;
      idx         <= '0;
      waddr_q     <= '0;
      cacheable_q <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (busy_next)      waddr_q     <= idx_next;
      if (!i_fetch_stall) cacheable_q <= cacheable_d;
    end
  end

  assign o_tag_wenable = (state == ST_FLUSH);
  assign o_tag_waddr   = waddr_q;
  assign o_tag_valid   = 1'b0;
  assign o_flush_busy  = (state == ST_FLUSH);
  assign o_flush_done  = (state == ST_DONE);
  assign o_cacheable   = cacheable_q;

endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// Bench for a23_cache_flush_ctrl: line-position model checked every cycle plus directed literal checks.
module tb_a23_cache_flush_ctrl;
  localparam int L = 256;
  localparam int IW = $clog2(L);

  logic          i_clk = 1'b0;
  logic          i_system_rdy = 1'b0;
  logic          i_fetch_stall = 1'b0;
  logic          i_cache_enable = 1'b0;
  logic          i_cache_flush = 1'b0;
  logic [31:0]   i_cacheable_area = '0;
  logic [31:0]   i_address = '0;
  logic          o_tag_wenable, o_tag_valid, o_flush_busy, o_flush_done, o_cacheable;
  logic [IW-1:0] o_tag_waddr;

  int checks = 0;
  int failures = 0;

  a23_cache_flush_ctrl #(.CACHE_LINES(L)) dut (
    .i_clk(i_clk), .i_system_rdy(i_system_rdy), .i_fetch_stall(i_fetch_stall),
    .i_cache_enable(i_cache_enable), .i_cache_flush(i_cache_flush),
    .i_cacheable_area(i_cacheable_area), .i_address(i_address),
    .o_tag_wenable(o_tag_wenable), .o_tag_waddr(o_tag_waddr), .o_tag_valid(o_tag_valid),
    .o_flush_busy(o_flush_busy), .o_flush_done(o_flush_done), .o_cacheable(o_cacheable)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: m_pos is the line written this cycle, -1 when not flushing.
  int   m_pos = -1;
  int   m_last = 0;
  bit   m_done = 1'b0;
  bit   m_cach = 1'b0;
`ifdef A23_FLUSH_ON_RESET_EN
  bit   m_boot = 1'b1;
`else
  bit   m_boot = 1'b0;
`endif

  always @(posedge i_clk or negedge i_system_rdy) begin
    bit req;
    if (!i_system_rdy) begin
      m_pos = -1; m_last = 0; m_done = 0; m_cach = 0;
`ifdef A23_FLUSH_ON_RESET_EN
      m_boot = 1;
`endif
    end else begin
      req = i_cache_flush || m_boot;
      m_boot = 0;
      m_done = (m_pos == L - 1) && !req;
      if (req) m_pos = 0;
      else if (m_pos >= 0) begin
        m_pos = m_pos + 1;
        if (m_pos == L) m_pos = -1;
      end
      if (m_pos >= 0) m_last = m_pos;
      if (!i_fetch_stall)
        m_cach = i_cache_enable && (i_address < 32'h0400_0000) &&
                 i_cacheable_area[int'(i_address >> 21) % 32] && (m_pos < 0);
    end
  end

  always @(negedge i_clk) begin
    chk("cmp_wenable", o_tag_wenable, m_pos >= 0);
    chk("cmp_waddr", o_tag_waddr, m_last);
    chk("cmp_valid", o_tag_valid, 0);
    chk("cmp_busy", o_flush_busy, m_pos >= 0);
    chk("cmp_done", o_flush_done, m_done);
    chk("cmp_cacheable", o_cacheable, m_cach);
  end

  task automatic pulse_flush();
    @(negedge i_clk); i_cache_flush = 1'b1;
    @(negedge i_clk); i_cache_flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge i_clk);
      if (!o_flush_busy && !o_flush_done) found = 1;
    end
    chk(name, found, 1);
  endtask

  task automatic wait_waddr(input string name, input int t);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge i_clk);
      if (o_tag_wenable && o_tag_waddr == IW'(t)) found = 1;
    end
    chk(name, found, 1);
  endtask

  initial begin
    int writes, dones;
    #3;
    chk("rst_wenable", o_tag_wenable, 0);
    chk("rst_waddr", o_tag_waddr, 0);
    chk("rst_busy", o_flush_busy, 0);
    chk("rst_done", o_flush_done, 0);
    chk("rst_cacheable", o_cacheable, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_system_rdy = 1'b1;
`ifdef A23_FLUSH_ON_RESET_EN
    @(negedge i_clk);
    chk("boot_busy", o_flush_busy, 1);
    wait_idle("boot_wait_idle");
`else
    repeat (3) @(negedge i_clk);
    chk("noboot_busy", o_flush_busy, 0);
`endif

    // full flush with literal latency pins; toggle enable mid-walk
    i_cache_enable = 1'b1; i_cacheable_area = 32'h0000_0004; i_address = 32'h0040_0000;
    pulse_flush();
    chk("f1_wen_first", o_tag_wenable, 1);
    chk("f1_addr_first", o_tag_waddr, 0);
    chk("f1_cach_busy", o_cacheable, 0);
    writes = 1; dones = 0;
    for (int k = 2; k <= L + 2; k++) begin
      @(negedge i_clk);
      if (k == 40) i_cache_enable = 1'b0;
      if (k == 80) i_cache_enable = 1'b1;
      writes += int'(o_tag_wenable);
      dones += int'(o_flush_done);
      if (k == L) begin
        chk("f1_addr_last", o_tag_waddr, L - 1);
        chk("f1_wen_last", o_tag_wenable, 1);
      end
      if (k == L + 1) begin
        chk("f1_done", o_flush_done, 1);
        chk("f1_busy_at_done", o_flush_busy, 0);
        chk("f1_wen_at_done", o_tag_wenable, 0);
        chk("f1_addr_hold", o_tag_waddr, L - 1);
      end
      if (k == L + 2) chk("f1_done_single", o_flush_done, 0);
    end
    chk("f1_writes", writes, L);
    chk("f1_dones", dones, 1);

    // cacheability
    chk("c_region2", o_cacheable, 1);
    i_address = 32'h0440_0000; @(negedge i_clk);
    chk("c_high_addr", o_cacheable, 0);
    i_address = 32'h0020_0000; @(negedge i_clk);
    chk("c_region1", o_cacheable, 0);
    i_address = 32'h0040_0000; i_cache_enable = 1'b0; @(negedge i_clk);
    chk("c_disabled", o_cacheable, 0);
    i_cache_enable = 1'b1; @(negedge i_clk);
    chk("c_enabled", o_cacheable, 1);

    // stall holds cacheable but not the flush walk
    i_fetch_stall = 1'b1; i_address = 32'h0440_0000;
    pulse_flush();
    chk("s_addr0", o_tag_waddr, 0);
    repeat (4) @(negedge i_clk);
    chk("s_addr4", o_tag_waddr, 4);
    chk("s_cach_hold", o_cacheable, 1);
    i_fetch_stall = 1'b0; @(negedge i_clk);
    chk("s_cach_release", o_cacheable, 0);
    wait_idle("s_wait_idle");

    // restart mid-flush
    i_address = 32'h0040_0000;
    pulse_flush();
    wait_waddr("r_wait100", 100);
    i_cache_flush = 1'b1; @(negedge i_clk); i_cache_flush = 1'b0;
    chk("r_addr0", o_tag_waddr, 0);
    chk("r_no_done", o_flush_done, 0);
    writes = 1; dones = 0;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge i_clk);
      writes += int'(o_tag_wenable);
      dones += int'(o_flush_done);
    end
    chk("r_writes", writes, L);
    chk("r_dones", dones, 1);

    // reset mid-flush
    pulse_flush();
    wait_waddr("x_wait50", 50);
    #2 i_system_rdy = 1'b0;
    #1;
    chk("x_wenable", o_tag_wenable, 0);
    chk("x_waddr", o_tag_waddr, 0);
    chk("x_busy", o_flush_busy, 0);
    chk("x_done", o_flush_done, 0);
    chk("x_cacheable", o_cacheable, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_system_rdy = 1'b1;
    writes = 0; dones = 0;
    for (int k = 0; k < L + 20; k++) begin
      @(negedge i_clk);
      writes += int'(o_tag_wenable);
      dones += int'(o_flush_done);
    end
`ifdef A23_FLUSH_ON_RESET_EN
    chk("x_post_writes", writes, L);
    chk("x_post_dones", dones, 1);
`else
    chk("x_post_writes", writes, 0);
    chk("x_post_dones", dones, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a23_cache_flush_ctrl.md
A23_CACHE_FLUSH_CTRL -- requirements
Module: a23_cache_flush_ctrl

Interface
REQ-001 SHALL have parameter CACHE_LINES, default 256, number of cache lines to invalidate; power of two, 4..1024.
REQ-002 SHALL have derived localparam IDX_W = log2(CACHE_LINES), the line-index width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_system_rdy, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port i_fetch_stall, input, 1, core-wide stall.
REQ-006 SHALL have port i_cache_enable, input, 1, cache on/off from CP15 reg 2 bit 0.
REQ-007 SHALL have port i_cache_flush, input, 1, single-cycle flush request from a CP15 reg 1 write.
REQ-008 SHALL have port i_cacheable_area, input, 32, one bit per 2MB region.
REQ-009 SHALL have port i_address, input, 32, current fetch/data address.
REQ-010 SHALL have port o_tag_wenable, output, 1, tag RAM write strobe.
REQ-011 SHALL have port o_tag_waddr, output, IDX_W, tag RAM line index.
REQ-012 SHALL have port o_tag_valid, output, 1, valid bit to write; constant 0.
REQ-013 SHALL have port o_flush_busy, output, 1, stall request to the core.
REQ-014 SHALL have port o_flush_done, output, 1, single-cycle completion pulse.
REQ-015 SHALL have port o_cacheable, output, 1, registered cacheability of i_address.

Function
REQ-016 SHALL implement FSM states IDLE, FLUSH and DONE; o_flush_busy = (state==FLUSH), o_flush_done = (state==DONE), both registered.
REQ-017 SHALL move IDLE->FLUSH and load index 0 on the edge where i_cache_flush=1.
REQ-018 In FLUSH, SHALL assert o_tag_wenable with o_tag_waddr=index and increment index every cycle, regardless of i_fetch_stall.
REQ-019 SHALL move FLUSH->DONE after writing index CACHE_LINES-1; index wraps to 0 and never exceeds CACHE_LINES-1.
REQ-020 Latency: flush pulse sampled at edge N -> writes to lines 0..CACHE_LINES-1 on cycles N+1..N+CACHE_LINES; o_flush_done high on cycle N+CACHE_LINES+1 only.
REQ-021 SHALL move DONE->IDLE, or DONE->FLUSH with index 0 if i_cache_flush=1 in DONE.
REQ-022 If i_cache_flush=1 during FLUSH, SHALL restart at index 0 on the next cycle with no DONE pulse in between.
REQ-023 SHALL NOT abort or alter a flush when i_cache_enable changes.
REQ-024 When i_fetch_stall=0, o_cacheable SHALL load i_cache_enable & (i_address[31:26]==0) & i_cacheable_area[i_address[25:21]] & ~busy_next, where busy_next=1 if the next state is FLUSH.
REQ-025 When i_fetch_stall=1, o_cacheable SHALL hold its value.
REQ-026 Addresses at or above 0x0400_0000 SHALL give o_cacheable=0.
REQ-027 o_tag_wenable SHALL be 0 outside FLUSH, with o_tag_waddr holding its last value.

Reset
REQ-028 While i_system_rdy=0, SHALL immediately force state IDLE, index 0, o_tag_wenable=0, o_tag_waddr=0, o_flush_busy=0, o_flush_done=0, o_cacheable=0.
REQ-029 A reset asserted mid-flush SHALL abandon it; no DONE pulse follows.

Configuration
REQ-030 Macro A23_FLUSH_ON_RESET_EN, when defined: first edge after i_system_rdy rises SHALL enter FLUSH at index 0 automatically, a full CACHE_LINES-cycle flush with DONE pulse.
REQ-031 Without A23_FLUSH_ON_RESET_EN, SHALL stay in IDLE after reset until i_cache_flush.

Verification
REQ-032 CACHE_LINES=256, pulse i_cache_flush at cycle 10 -> wenable cycles 11..266, waddr 0..255, done=1 only at cycle 267, busy low at 267.
REQ-033 Second flush pulse at waddr=100 -> waddr=0 next cycle, 256 more writes, exactly one done pulse.
REQ-034 enable=1, area=0x0000_0004, addr=0x0040_0000 -> o_cacheable=1; addr=0x0440_0000 -> 0; enable=0 -> 0.
REQ-035 Hold i_fetch_stall=1 and change i_address -> o_cacheable unchanged; flush index still advances.
REQ-036 Drop i_system_rdy at waddr=50 -> all outputs 0 asynchronously; after release, behaviour per REQ-030/REQ-031 for the active build.
